// File: rtl/stack_ptr_unit.sv
// stack_ptr_unit: stack pointer, depth counter and full/empty status for the
// CoCC datapath. Push post-decrements SP, pop pre-increments it, and `tos`
// gives the address of the top element. SP can be driven onto a shared
// tri-state bus.
// Optional feature: define STACK_GUARD_EN to block overflow/underflow and
// latch sticky `ovf`/`unf` flags; without it SP and depth simply wrap.
module stack_ptr_unit #(
    parameter int unsigned          WIDTH  = 8,
    parameter logic [WIDTH-1:0]     TOP    = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0]     BOTTOM = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             set,
    input  logic [WIDTH-1:0] in,
    input  logic             oe,
    output wire  [WIDTH-1:0] out,
    output logic [WIDTH-1:0] sp,
    output logic [WIDTH-1:0] tos,
    output logic [WIDTH:0]   depth,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             unf
);

    // Number of usable slots. This is one bit wider than SP so that a stack
    // spanning the whole 2^WIDTH address space can be represented.
    localparam logic [WIDTH:0] CAPACITY = {1'b0, TOP} - {1'b0, BOTTOM} + 1'b1;

    logic [WIDTH-1:0] sp_q, sp_next;
    logic [WIDTH:0]   depth_q, depth_next;
    logic             push_only, pop_only;

    assign push_only = push & ~pop;
    assign pop_only  = pop & ~push;

    // Status and addresses are pure functions of the registered state.
    assign sp    = sp_q;
    assign depth = depth_q;
    assign tos   = sp_q + 1'b1;
    assign full  = (depth_q == CAPACITY);
    assign empty = (depth_q == '0);

    // Bus driver: released whenever oe is low, reset included.
    assign out = oe ? sp_q : {WIDTH{1'bz}};

`ifdef STACK_GUARD_EN
    logic ovf_q, ovf_next;
    logic unf_q, unf_next;

    assign ovf = ovf_q;
    assign unf = unf_q;

    // Next-state logic with overflow/underflow blocking.
    always_comb begin
        // NOTE: every output of this block is given a default first so no
        // path leaves it unassigned, which would infer a latch.
        sp_next    = sp_q;
        depth_next = depth_q;
        ovf_next   = ovf_q;
        unf_next   = unf_q;
        if (set) begin
            sp_next    = in;
            depth_next = {1'b0, TOP} - {1'b0, in};
            ovf_next   = 1'b0;
            unf_next   = 1'b0;
        end else if (push_only) begin
            if (full) begin
                ovf_next = 1'b1;
            end else begin
                sp_next    = sp_q - 1'b1;
                depth_next = depth_q + 1'b1;
            end
        end else if (pop_only) begin
            if (empty) begin
                unf_next = 1'b1;
            end else begin
                sp_next    = sp_q + 1'b1;
                depth_next = depth_q - 1'b1;
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (reset) begin
            sp_q    <= TOP;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            sp_q    <= sp_next;
            depth_q <= depth_next;
            ovf_q   <= ovf_next;
            unf_q   <= unf_next;
        end
    end
`else
    assign ovf = 1'b0;
    assign unf = 1'b0;

    // Next-state logic; SP and depth wrap freely.
    always_comb begin
        // NOTE: every output of this block is given a default first so no
        // path leaves it unassigned, which would infer a latch.
        sp_next    = sp_q;
        depth_next = depth_q;
        if (set) begin
            sp_next    = in;
            depth_next = {1'b0, TOP} - {1'b0, in};
        end else if (push_only) begin
            sp_next    = sp_q - 1'b1;
            depth_next = depth_q + 1'b1;
        end else if (pop_only) begin
            sp_next    = sp_q + 1'b1;
            depth_next = depth_q - 1'b1;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (reset) begin
            sp_q    <= TOP;
            depth_q <= '0;
        end else begin
            sp_q    <= sp_next;
            depth_q <= depth_next;
        end
    end
`endif

endmodule

// File: tb/tb_stack_ptr_unit.sv
// Testbench for stack_ptr_unit (WIDTH=8, TOP=8'hFF, BOTTOM=8'hFC, i.e. a
// four-entry stack). Directed vectors carry hand-computed expected state.
// The driver queues the expected state after each edge, and a monitor on the
// falling edge pops and compares it. A second bus driver pulls the shared bus
// to 8'hA5 whenever the DUT should be high-Z.
module tb_stack_ptr_unit;

    localparam int unsigned WIDTH = 8;

    typedef struct packed {
        logic        oe;
        logic [7:0]  sp;
        logic [8:0]  depth;
        logic        ovf;
        logic        unf;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic        set = 1'b0;
    logic [7:0]  in = 8'h00;
    logic        oe = 1'b0;
    wire  [7:0]  bus;
    logic [7:0]  sp, tos;
    logic [8:0]  depth;
    logic        full, empty, ovf, unf;

    exp_t        sb_q[$];
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    // Other bus master: drives a marker value whenever the DUT must release.
    assign bus = oe ? 8'hzz : 8'hA5;

    stack_ptr_unit #(
        .WIDTH (WIDTH),
        .TOP   (8'hFF),
        .BOTTOM(8'hFC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .pop  (pop),
        .set  (set),
        .in   (in),
        .oe   (oe),
        .out  (bus),
        .sp   (sp),
        .tos  (tos),
        .depth(depth),
        .full (full),
        .empty(empty),
        .ovf  (ovf),
        .unf  (unf)
    );

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (vector %0d)", name, act, req, vectors);
        end
    endtask

    // Monitor: compares DUT outputs against the oldest queued expectation.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("sp",    {1'b0, sp},  {1'b0, e.sp});
            check("tos",   {1'b0, tos}, {1'b0, e.sp + 8'h01});
            check("depth", depth,       e.depth);
            check("full",  {8'h00, full},  {8'h00, e.depth == 9'd4});
            check("empty", {8'h00, empty}, {8'h00, e.depth == 9'd0});
            check("ovf",   {8'h00, ovf},   {8'h00, e.ovf});
            check("unf",   {8'h00, unf},   {8'h00, e.unf});
            check("out",   {1'b0, bus},    {1'b0, e.oe ? e.sp : 8'hA5});
        end
    end

    // Applies one vector for one edge and queues the state expected after it.
    task automatic apply(input logic r, input logic s, input logic [7:0] din,
                         input logic pu, input logic po, input logic o,
                         input logic [7:0] x_sp, input logic [8:0] x_depth,
                         input logic x_ovf, input logic x_unf);
        exp_t e;
        @(negedge clk);
        #1;
        reset = r; set = s; in = din; push = pu; pop = po; oe = o;
        @(posedge clk);
        #1;
        e.oe = o; e.sp = x_sp; e.depth = x_depth; e.ovf = x_ovf; e.unf = x_unf;
        sb_q.push_back(e);
        vectors++;
    endtask

    initial begin
        //     rst set in     push pop oe   sp     depth   ovf  unf
        apply(1, 0, 8'h00, 0, 0, 0, 8'hFF, 9'd0,   0, 0);  // reset state
        apply(0, 0, 8'h00, 1, 0, 0, 8'hFE, 9'd1,   0, 0);
        apply(0, 0, 8'h00, 1, 0, 0, 8'hFD, 9'd2,   0, 0);
        apply(0, 0, 8'h00, 1, 0, 0, 8'hFC, 9'd3,   0, 0);  // tos = FD
        apply(0, 0, 8'h00, 0, 1, 0, 8'hFD, 9'd2,   0, 0);
        apply(0, 0, 8'h00, 0, 1, 0, 8'hFE, 9'd1,   0, 0);
        apply(0, 0, 8'h00, 1, 0, 0, 8'hFD, 9'd2,   0, 0);
        apply(0, 0, 8'h00, 1, 1, 0, 8'hFD, 9'd2,   0, 0);  // replace-top
        apply(0, 1, 8'h80, 1, 0, 0, 8'h80, 9'h07F, 0, 0);  // set beats push
        apply(0, 0, 8'h00, 0, 0, 1, 8'h80, 9'h07F, 0, 0);  // bus shows SP
        apply(1, 0, 8'h00, 0, 0, 1, 8'hFF, 9'd0,   0, 0);
        apply(0, 0, 8'h00, 1, 0, 0, 8'hFE, 9'd1,   0, 0);
        apply(0, 0, 8'h00, 1, 0, 0, 8'hFD, 9'd2,   0, 0);
        apply(0, 0, 8'h00, 1, 0, 0, 8'hFC, 9'd3,   0, 0);
        apply(0, 0, 8'h00, 1, 0, 0, 8'hFB, 9'd4,   0, 0);  // full
`ifdef STACK_GUARD_EN
        apply(0, 0, 8'h00, 1, 0, 0, 8'hFB, 9'd4,   1, 0);  // blocked push
        apply(0, 0, 8'h00, 1, 1, 0, 8'hFB, 9'd4,   1, 0);  // ovf sticky
        apply(1, 0, 8'h00, 0, 0, 0, 8'hFF, 9'd0,   0, 0);
        apply(0, 0, 8'h00, 0, 1, 0, 8'hFF, 9'd0,   0, 1);  // blocked pop
        apply(0, 0, 8'h00, 0, 0, 0, 8'hFF, 9'd0,   0, 1);  // unf sticky
        apply(0, 1, 8'hFE, 0, 0, 0, 8'hFE, 9'd1,   0, 0);  // set clears flags
        apply(0, 0, 8'h00, 0, 1, 0, 8'hFF, 9'd0,   0, 0);
        apply(0, 0, 8'h00, 0, 1, 0, 8'hFF, 9'd0,   0, 1);
`else
        apply(0, 0, 8'h00, 1, 0, 0, 8'hFA, 9'd5,   0, 0);  // push past full
        apply(0, 0, 8'h00, 1, 1, 0, 8'hFA, 9'd5,   0, 0);
        apply(1, 0, 8'h00, 0, 0, 0, 8'hFF, 9'd0,   0, 0);
        apply(0, 0, 8'h00, 0, 1, 0, 8'h00, 9'h1FF, 0, 0);  // pop wraps
        apply(0, 0, 8'h00, 0, 0, 0, 8'h00, 9'h1FF, 0, 0);
        apply(0, 1, 8'hFE, 0, 0, 0, 8'hFE, 9'd1,   0, 0);
        apply(0, 0, 8'h00, 0, 1, 0, 8'hFF, 9'd0,   0, 0);
        apply(0, 0, 8'h00, 0, 1, 0, 8'h00, 9'h1FF, 0, 0);
`endif
        apply(1, 0, 8'h00, 1, 0, 0, 8'hFF, 9'd0,   0, 0);  // reset beats push
        apply(0, 0, 8'h00, 0, 0, 1, 8'hFF, 9'd0,   0, 0);
        apply(0, 0, 8'h00, 0, 0, 0, 8'hFF, 9'd0,   0, 0);

        // Let the monitor consume the last expectation, bounded in time.
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
